// File: rtl/snn_config_sequencer_if.sv
// snn_config_sequencer_if: byte-stream input handshake and register-write bus of the SNN config sequencer
//   rx_data/rx_valid/rx_ready : byte stream into the sequencer (transfer when valid and ready)
//   cfg_addr/cfg_data/cfg_we  : registered network register write port
//   master : byte source / register sink side; slave : sequencer side
interface snn_config_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_we;
    modport master (output rx_data, rx_valid, input rx_ready, cfg_addr, cfg_data, cfg_we);
    modport slave (input rx_data, rx_valid, output rx_ready, cfg_addr, cfg_data, cfg_we);
endinterface

// File: rtl/snn_config_sequencer.sv
// snn_config_sequencer: parses SYNC/N/(addr,data)xN/checksum frames, then replays the buffered pairs as register writes
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset
//   bus      : rx byte handshake in, cfg register write port out (slave modport)
//   net_hold : high while a frame is in progress (gates network input spikes)
//   done     : one-cycle pulse after a frame has been committed
//   err      : sticky frame error, cleared by the next accepted SYNC_BYTE
//   err_code : 01 bad count, 10 bad address, 11 bad checksum
module snn_config_sequencer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_ADDR  = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    snn_config_sequencer_if.slave       bus,
    output logic                        net_hold,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  err_code
);
    typedef enum logic [2:0] {IDLE, COUNT, ADDR, DATA, CSUM, COMMIT} state_t;
    state_t     state, state_n;
    logic [3:0] buf_a [15];
    logic [7:0] buf_d [15];
    logic [3:0] cnt, idx, cur_a, sel;
    logic [7:0] sum, sum_n;
    logic       xfer, count_ok, addr_ok, last_pair;
    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign count_ok  = bus.rx_data[7:4] == 4'd0 && bus.rx_data[3:0] != 4'd0;
    assign addr_ok   = bus.rx_data <= 8'(MAX_ADDR);
    assign sum_n     = sum + bus.rx_data;
    assign last_pair = idx == cnt - 4'd1;
    // pair 0 is launched on the checksum edge, later pairs come from the running index
    assign sel       = state == CSUM ? 4'd0 : idx;
    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (xfer && bus.rx_data == SYNC_BYTE) state_n = COUNT;
            COUNT:   if (xfer) state_n = count_ok ? ADDR : IDLE;
            ADDR:    if (xfer) state_n = addr_ok ? DATA : IDLE;
            DATA:    if (xfer) state_n = last_pair ? CSUM : ADDR;
            CSUM:    if (xfer) state_n = sum_n == 8'd0 ? COMMIT : IDLE;
            COMMIT:  if (idx == cnt) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.rx_ready <= 1'b0;
            bus.cfg_we   <= 1'b0;
            bus.cfg_addr <= 4'd0;
            bus.cfg_data <= 8'd0;
            net_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
            cnt          <= 4'd0;
            idx          <= 4'd0;
            cur_a        <= 4'd0;
            sum          <= 8'd0;
        end else begin
            // status outputs are registered from the next state so they line up with it
            bus.rx_ready <= state_n != COMMIT;
            net_hold     <= state_n != IDLE;
            done         <= state == COMMIT && state_n == IDLE;
            bus.cfg_we   <= state_n == COMMIT;
            if (state_n == COMMIT) begin
                bus.cfg_addr <= buf_a[sel];
                bus.cfg_data <= buf_d[sel];
                idx          <= sel + 4'd1;
            end
            if (xfer) begin
                if (state == IDLE && bus.rx_data == SYNC_BYTE) begin
                    err      <= 1'b0;
                    err_code <= 2'b00;
                end
                if (state == COUNT) begin
                    cnt <= bus.rx_data[3:0];
                    sum <= bus.rx_data;
                    idx <= 4'd0;
                end
                if (state == ADDR || state == DATA) sum <= sum_n;
                if (state == ADDR) cur_a <= bus.rx_data[3:0];
                if (state == DATA) begin
                    buf_a[idx] <= cur_a;
                    buf_d[idx] <= bus.rx_data;
                    idx        <= idx + 4'd1;
                end
                // only COUNT, ADDR and CSUM can fall back to IDLE on a byte, each for its own cause
                if (state != IDLE && state_n == IDLE) begin
                    err      <= 1'b1;
                    err_code <= state == COUNT ? 2'b01 : state == ADDR ? 2'b10 : 2'b11;
                end
            end
        end
    end
endmodule

// File: tb/tb_snn_config_sequencer.sv
// tb_snn_config_sequencer: directed frames with a write scoreboard for snn_config_sequencer
module tb_snn_config_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       net_hold, done, err;
    logic [1:0] err_code;
    int         checks = 0;
    int         errors = 0;
    logic [11:0] exp_q [$];
    logic [3:0] fa [15];
    logic [7:0] fd [15];

    snn_config_sequencer_if bus();

    snn_config_sequencer dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .net_hold(net_hold),
        .done(done),
        .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // present a byte from a negedge and return at the negedge after it transfers
    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t == 200) chk("rx_ready_timeout", {31'd0, bus.rx_ready}, 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // called at the negedge right after the checksum byte transfers
    task automatic commit_check(input int n);
        chk("we_first_cycle", {31'd0, bus.cfg_we}, 1);
        chk("rx_ready_in_commit", {31'd0, bus.rx_ready}, 0);
        chk("net_hold_in_commit", {31'd0, net_hold}, 1);
        repeat (n) @(negedge clk);
        chk("done_pulse", {31'd0, done}, 1);
        chk("we_low_at_done", {31'd0, bus.cfg_we}, 0);
        chk("net_hold_at_done", {31'd0, net_hold}, 0);
        chk("rx_ready_at_done", {31'd0, bus.rx_ready}, 1);
        chk("writes_drained", exp_q.size(), 0);
        chk("err_good_frame", {31'd0, err}, 0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
    endtask

    task automatic frame(input int n, input bit gaps, input bit wait_done);
        logic [7:0] s;
        send(8'hA5);
        chk("net_hold_after_sync", {31'd0, net_hold}, 1);
        chk("err_cleared_by_sync", {29'd0, err, err_code}, 0);
        send(8'(n));
        s = 8'(n);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send({4'h0, fa[i]});
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(fd[i]);
            s = s + {4'h0, fa[i]} + fd[i];
            exp_q.push_back({fa[i], fd[i]});
        end
        send(8'(0 - s));
        if (wait_done) commit_check(n);
    endtask

    initial begin
        logic [11:0] e;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (bus.cfg_we === 1'b1) begin
                    if (exp_q.size() == 0) chk("spurious_cfg_we", {31'd0, bus.cfg_we}, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("cfg_write", {20'd0, bus.cfg_addr, bus.cfg_data}, {20'd0, e});
                    end
                end
            end
        join_none
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", {31'd0, bus.rx_ready}, 0);
        chk("rst_cfg_we", {31'd0, bus.cfg_we}, 0);
        chk("rst_cfg_addr", {28'd0, bus.cfg_addr}, 0);
        chk("rst_cfg_data", {24'd0, bus.cfg_data}, 0);
        chk("rst_status", {27'd0, net_hold, done, err, err_code}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_reset", {31'd0, bus.rx_ready}, 1);
        chk("idle_net_hold", {31'd0, net_hold}, 0);

        // literal example frame
        exp_q.push_back({4'h0, 8'h80});
        exp_q.push_back({4'h3, 8'h10});
        send(8'hA5); send(8'h02); send(8'h00); send(8'h80); send(8'h03); send(8'h10); send(8'h6B);
        commit_check(2);
        chk("cfg_hold_after_commit", {20'd0, bus.cfg_addr, bus.cfg_data}, {20'd0, 4'h3, 8'h10});

        // bad checksum
        send(8'hA5); send(8'h02); send(8'h00); send(8'h80); send(8'h03); send(8'h10); send(8'h6C);
        chk("csum_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b11});
        chk("csum_net_hold_falls", {31'd0, net_hold}, 0);
        chk("csum_no_we", {31'd0, bus.cfg_we}, 0);
        repeat (3) @(negedge clk);
        chk("cfg_hold_while_idle", {20'd0, bus.cfg_addr, bus.cfg_data}, {20'd0, 4'h3, 8'h10});

        // good frame clears err; duplicates, max address and SYNC_BYTE as data
        fa[0] = 4'h5; fd[0] = 8'hA5;
        fa[1] = 4'h5; fd[1] = 8'h11;
        fa[2] = 4'hE; fd[2] = 8'hA5;
        frame(3, 1'b0, 1'b1);

        // bad address then discarded bytes
        send(8'hA5); send(8'h01); send(8'h0F);
        chk("addr_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b10});
        chk("addr_err_net_hold", {31'd0, net_hold}, 0);
        send(8'h02); send(8'h00); send(8'h80); send(8'h03); send(8'h10); send(8'h6B);
        chk("discard_keeps_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b10});
        chk("discard_idle", {31'd0, net_hold}, 0);
        send(8'hA5); send(8'h01); send(8'h10);
        chk("addr_upper_nibble_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b10});

        // bad counts
        send(8'hA5); send(8'h00);
        chk("count_zero_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b01});
        send(8'hA5);
        chk("sync_clears_err", {29'd0, err, err_code}, 0);
        send(8'h10);
        chk("count_16_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b01});

        // 15 pairs with gaps, then the next frame presented across COMMIT
        for (int i = 0; i < 15; i++) begin
            fa[i] = 4'($urandom_range(0, 14));
            fd[i] = 8'($urandom);
        end
        frame(15, 1'b1, 1'b0);
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        chk("rx_ready_low_commit15", {31'd0, bus.rx_ready}, 0);
        chk("we_commit15", {31'd0, bus.cfg_we}, 1);
        fa[0] = 4'h7; fd[0] = 8'h3C;
        fa[1] = 4'h0; fd[1] = 8'hFF;
        frame(2, 1'b0, 1'b1);

        // reset during the second of four writes
        fa[0] = 4'h1; fd[0] = 8'h11;
        fa[1] = 4'h2; fd[1] = 8'h22;
        fa[2] = 4'h3; fd[2] = 8'h33;
        fa[3] = 4'h4; fd[3] = 8'h44;
        frame(4, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_commit_rst_we", {31'd0, bus.cfg_we}, 0);
        chk("mid_commit_rst_cfg", {20'd0, bus.cfg_addr, bus.cfg_data}, 0);
        chk("mid_commit_rst_status", {27'd0, net_hold, done, err, err_code}, 0);
        chk("mid_commit_rst_rx_ready", {31'd0, bus.rx_ready}, 0);
        chk("writes_before_rst", exp_q.size(), 2);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_rx_ready", {31'd0, bus.rx_ready}, 1);
        chk("post_rst_no_done", {31'd0, done}, 0);
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", {29'd0, bus.cfg_we, done, net_hold}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
